// File: rtl/safety_boot_ctrl_regs.sv
// AXI4-Lite register block that holds the safety-island boot controls and
// sequences the core's fetch enable and boot address through a small boot FSM.
module safety_boot_ctrl_regs #(
  parameter int unsigned AddrWidth   = 32,
  parameter logic [31:0] RomBootAddr = 32'h1A00_0080,
  parameter int unsigned RstHoldCyc  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [31:0]          w_data_i,
  input  logic [3:0]           w_strb_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [31:0]          r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [31:0]          core_boot_addr_o,
  output logic                 core_fetch_en_o,
  output logic                 eoc_o,
  output logic [30:0]          exit_code_o
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam int unsigned CntW = $clog2(RstHoldCyc + 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT,
    ST_RUN,
    ST_DONE
  } boot_state_t;

  boot_state_t state_q, state_d;
  logic [CntW-1:0] hold_cnt;

  logic        ready_en;
  logic        aw_held, w_held;
  logic [1:0]  aw_idx;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        wr_commit;

  logic [1:0]  bootmode_q;
  logic [31:0] boot_addr_q;
  logic [31:0] eoc_q;

  logic [31:0] old_val, wr_merged, rd_mux;
  logic [1:0]  wr_resp;
  logic        locked;
  logic        bootmode_we, boot_addr_we, eoc_we, eoc_set, fetch_req;
  logic        load_rom, load_boot;

  // Only addr[3:2] selects a register; the remaining address bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{aw_addr_i[AddrWidth-1:4], aw_addr_i[1:0],
                         ar_addr_i[AddrWidth-1:4], ar_addr_i[1:0]};

  // Keeps every ready low while reset is applied and for the release edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ready_en <= 1'b0;
    else         ready_en <= 1'b1;
  end

  assign aw_ready_o = ready_en && !aw_held && !b_valid_o;
  assign w_ready_o  = ready_en && !w_held && !b_valid_o;
  assign ar_ready_o = ready_en && !r_valid_o;
  assign r_resp_o   = RespOkay;
  assign wr_commit  = aw_held && w_held;
  assign locked     = (state_q == ST_RUN) || (state_q == ST_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held   <= 1'b0;
      aw_idx    <= 2'd0;
      w_held    <= 1'b0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      b_valid_o <= 1'b0;
      b_resp_o  <= RespOkay;
    end else if (wr_commit) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      b_valid_o <= 1'b1;
      b_resp_o  <= wr_resp;
    end else begin
      if (b_valid_o && b_ready_i) b_valid_o <= 1'b0;
      if (aw_valid_i && aw_ready_o) begin
        aw_held <= 1'b1;
        aw_idx  <= aw_addr_i[3:2];
      end
      if (w_valid_i && w_ready_o) begin
        w_held   <= 1'b1;
        w_data_q <= w_data_i;
        w_strb_q <= w_strb_i;
      end
    end
  end

  always_comb begin
    old_val = 32'd0;
    case (aw_idx)
      2'd0:    old_val = {30'd0, bootmode_q};
      2'd1:    old_val = boot_addr_q;
      2'd3:    old_val = eoc_q;
      default: old_val = 32'd0;
    endcase
    wr_merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (w_strb_q[i]) wr_merged[i*8 +: 8] = w_data_q[i*8 +: 8];
    end
  end

  // Boot configuration freezes once the core runs; mode 3 is reserved.
  always_comb begin
    wr_resp      = RespOkay;
    bootmode_we  = 1'b0;
    boot_addr_we = 1'b0;
    eoc_we       = 1'b0;
    eoc_set      = 1'b0;
    fetch_req    = 1'b0;
    if (wr_commit) begin
      case (aw_idx)
        2'd0: begin
          if (locked || wr_merged[1:0] == 2'b11) wr_resp = RespSlvErr;
          else                                   bootmode_we = 1'b1;
        end
        2'd1: begin
          if (locked) wr_resp = RespSlvErr;
          else        boot_addr_we = 1'b1;
        end
        2'd2: fetch_req = w_strb_q[0] && w_data_q[0];
        default: begin
          eoc_we  = (state_q != ST_DONE);
          eoc_set = w_strb_q[3] && w_data_q[31];
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bootmode_q  <= 2'd0;
      boot_addr_q <= 32'd0;
      eoc_q       <= 32'd0;
    end else begin
      if (bootmode_we)  bootmode_q  <= wr_merged[1:0];
      if (boot_addr_we) boot_addr_q <= wr_merged;
      if (eoc_we)       eoc_q       <= wr_merged;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_rom  = 1'b0;
    load_boot = 1'b0;
    case (state_q)
      ST_HOLD: if (hold_cnt == CntW'(RstHoldCyc)) state_d = ST_WAIT;
      ST_WAIT: begin
        if (bootmode_q == 2'd0) begin
          state_d  = ST_RUN;
          load_rom = 1'b1;
        end else if (fetch_req) begin
          state_d   = ST_RUN;
          load_boot = 1'b1;
        end
      end
      ST_RUN:  if (eoc_we && eoc_set) state_d = ST_DONE;
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_HOLD;
      hold_cnt         <= '0;
      core_boot_addr_o <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_HOLD) hold_cnt <= hold_cnt + CntW'(1);
      if (load_rom)       core_boot_addr_o <= RomBootAddr;
      else if (load_boot) core_boot_addr_o <= boot_addr_q;
    end
  end

  assign core_fetch_en_o = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign eoc_o           = eoc_q[31];
  assign exit_code_o     = eoc_q[30:0];

  always_comb begin
    rd_mux = 32'd0;
    case (ar_addr_i[3:2])
      2'd0:    rd_mux = {30'd0, bootmode_q};
      2'd1:    rd_mux = boot_addr_q;
      2'd2:    rd_mux = {31'd0, core_fetch_en_o};
      default: rd_mux = eoc_q;
    endcase
  end

  // Read data is captured from pre-write state, so a same-cycle write is not seen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_data_o  <= 32'd0;
    end else if (ar_valid_i && ar_ready_o) begin
      r_valid_o <= 1'b1;
      r_data_o  <= rd_mux;
    end else if (r_valid_o && r_ready_i) begin
      r_valid_o <= 1'b0;
    end
  end

endmodule
